// File: rtl/exe_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair: 32-step shift-add / restoring divide.
// Optional macro MULDIV_SIGNED_EN adds signed mult/div (op[0] = 0) via magnitude + sign fix-up.
module exe_muldiv_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] Read_data_1,
   input  logic [31:0] Read_data_2,
   input  logic        hi_we,
   input  logic        lo_we,
   output logic        busy,
   output logic        done,
   output logic        div0,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  count_reg;
   logic        is_div_reg;
   logic        div0_flag_reg;
   logic [31:0] opnd_reg;
   logic [31:0] hi_acc_reg;
   logic [31:0] lo_acc_reg;
   logic [31:0] raw_a_reg;
   logic [31:0] hi_reg, lo_reg;
   logic        done_reg, div0_reg;

   logic [31:0] a_mag, b_mag;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
   logic        is_signed;
   logic        a_neg, b_neg;
   logic        neg_q_reg, neg_r_reg;

   assign is_signed = ~op[0];
   assign a_neg     = is_signed & Read_data_1[31];
   assign b_neg     = is_signed & Read_data_2[31];
   assign a_mag     = a_neg ? (32'd0 - Read_data_1) : Read_data_1;
   assign b_mag     = b_neg ? (32'd0 - Read_data_2) : Read_data_2;

   // Product and quotient share the a^b sign; remainder follows the dividend.
   always_ff @(posedge clock) begin
      if (reset) begin
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
      end else if (state_reg == S_IDLE && start) begin
         neg_q_reg <= a_neg ^ b_neg;
         neg_r_reg <= a_neg;
      end
   end

   assign prod_fix = neg_q_reg ? (64'd0 - {hi_acc_reg, lo_acc_reg}) : {hi_acc_reg, lo_acc_reg};
   assign quo_fix  = neg_q_reg ? (32'd0 - lo_acc_reg) : lo_acc_reg;
   assign rem_fix  = neg_r_reg ? (32'd0 - hi_acc_reg) : hi_acc_reg;
`else
   logic unused_op_sign;
   assign unused_op_sign = op[0];   // signedness select has no meaning in this build
   assign a_mag    = Read_data_1;
   assign b_mag    = Read_data_2;
   assign prod_fix = {hi_acc_reg, lo_acc_reg};
   assign quo_fix  = lo_acc_reg;
   assign rem_fix  = hi_acc_reg;
`endif

   // One iteration of each loop; hi_acc doubles as multiply accumulator and divide remainder.
   logic [32:0] add_sum;
   logic [32:0] rem_sh;
   logic        rem_ge;
   logic [31:0] rem_diff;

   assign add_sum  = {1'b0, hi_acc_reg} + {1'b0, (lo_acc_reg[0] ? opnd_reg : 32'd0)};
   assign rem_sh   = {hi_acc_reg, lo_acc_reg[31]};
   assign rem_ge   = rem_sh >= {1'b0, opnd_reg};
   assign rem_diff = rem_sh[31:0] - opnd_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (start) state_next = S_RUN;
         S_RUN:  if (count_reg == 5'd31) state_next = S_FIX;
         S_FIX:  state_next = S_DONE;
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg     <= 5'd0;
         is_div_reg    <= 1'b0;
         div0_flag_reg <= 1'b0;
         opnd_reg      <= 32'd0;
         hi_acc_reg    <= 32'd0;
         lo_acc_reg    <= 32'd0;
         raw_a_reg     <= 32'd0;
         hi_reg        <= 32'd0;
         lo_reg        <= 32'd0;
         done_reg      <= 1'b0;
         div0_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         div0_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  count_reg     <= 5'd0;
                  is_div_reg    <= op[1];
                  div0_flag_reg <= op[1] & (Read_data_2 == 32'd0);
                  raw_a_reg     <= Read_data_1;
                  hi_acc_reg    <= 32'd0;
                  lo_acc_reg    <= op[1] ? a_mag : b_mag;
                  opnd_reg      <= op[1] ? b_mag : a_mag;
               end else begin
                  if (hi_we) hi_reg <= Read_data_1;
                  if (lo_we) lo_reg <= Read_data_1;
               end
            end
            S_RUN: begin
               count_reg <= count_reg + 5'd1;
               if (is_div_reg) begin
                  hi_acc_reg <= rem_ge ? rem_diff : rem_sh[31:0];
                  lo_acc_reg <= {lo_acc_reg[30:0], rem_ge};
               end else begin
                  hi_acc_reg <= add_sum[32:1];
                  lo_acc_reg <= {add_sum[0], lo_acc_reg[31:1]};
               end
            end
            S_FIX: begin
               done_reg <= 1'b1;
               div0_reg <= div0_flag_reg;
               if (!is_div_reg) begin
                  hi_reg <= prod_fix[63:32];
                  lo_reg <= prod_fix[31:0];
               end else if (div0_flag_reg) begin
                  hi_reg <= raw_a_reg;
                  lo_reg <= 32'hFFFF_FFFF;
               end else begin
                  hi_reg <= rem_fix;
                  lo_reg <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_reg != S_IDLE);
   assign done = done_reg;
   assign div0 = div0_reg;
   assign HI   = hi_reg;
   assign LO   = lo_reg;

endmodule
